// File: rtl/spike_aer_out.sv
// Output spike FIFO plus 4-phase REQ/ACK AER transmitter with occupancy and drop status.
// Optional macro SPIKE_AER_ACK_SYNC_EN adds a 2-flop synchronizer on aerout_ack_i.
module spike_aer_out #(
    parameter int M      = 8,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     neuron_spike_i,
    input  logic [M-1:0]             neuron_idx_i,
    input  logic                     clr_status_i,
    output logic [M-1:0]             aerout_addr_o,
    output logic                     aerout_req_o,
    input  logic                     aerout_ack_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     fifo_empty_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, REQ, ACKLO} aer_st_t;

    aer_st_t          st;
    logic [M-1:0]     mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    count_nxt;
    logic             full, empty, push, pop, drop, ack_s;

`ifdef SPIKE_AER_ACK_SYNC_EN
    logic [1:0] ack_sync;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ack_sync <= 2'b00;
        else        ack_sync <= {ack_sync[0], aerout_ack_i};
    end
    assign ack_s = ack_sync[1];
`else
    assign ack_s = aerout_ack_i;
`endif

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = (st == REQ) && ack_s;
    assign push  = neuron_spike_i && (!full || pop);
    assign drop  = neuron_spike_i && full && !pop;

    always_comb begin
        count_nxt = fifo_count_o;
        if (push && !pop)      count_nxt = fifo_count_o + PW'(1);
        else if (pop && !push) count_nxt = fifo_count_o - PW'(1);
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= neuron_idx_i;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count_o <= '0;
            fifo_empty_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_count_o <= count_nxt;
            fifo_empty_o <= (count_nxt == '0);
        end
    end

    // A drop in the same cycle as a clear leaves exactly that one drop recorded.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (clr_status_i)          drop_cnt_o <= DROP_W'(1);
            else if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
        end else if (clr_status_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

    // Address is loaded one cycle before REQ rises so it is stable at the receiver.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st            <= IDLE;
            aerout_addr_o <= '0;
            aerout_req_o  <= 1'b0;
        end else begin
            case (st)
                IDLE: if (!empty) begin
                    aerout_addr_o <= mem[rd_ptr[AW-1:0]];
                    st            <= SETUP;
                end
                SETUP: begin
                    aerout_req_o <= 1'b1;
                    st           <= REQ;
                end
                REQ: if (ack_s) begin
                    aerout_req_o <= 1'b0;
                    st           <= ACKLO;
                end
                ACKLO: if (!ack_s) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_aer_out.sv
// Self-checking bench for spike_aer_out: queue-based FIFO model plus a polled AER receiver.
module tb_spike_aer_out;
    localparam int M = 8, DEPTH = 16, DROP_W = 8;
`ifdef SPIKE_AER_ACK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic CLK = 1'b0, RST_N = 1'b0;
    logic neuron_spike_i = 1'b0, clr_status_i = 1'b0, aerout_ack_i = 1'b0;
    logic [M-1:0] neuron_idx_i = '0;
    logic [M-1:0] aerout_addr_o;
    logic aerout_req_o, fifo_empty_o, overflow_o;
    logic [$clog2(DEPTH):0] fifo_count_o;
    logic [DROP_W-1:0] drop_cnt_o;

    int n_chk = 0, n_fail = 0;
    logic [M-1:0] q[$];

    spike_aer_out #(.M(M), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .neuron_spike_i(neuron_spike_i), .neuron_idx_i(neuron_idx_i),
        .clr_status_i(clr_status_i), .aerout_addr_o(aerout_addr_o), .aerout_req_o(aerout_req_o),
        .aerout_ack_i(aerout_ack_i), .fifo_count_o(fifo_count_o), .fifo_empty_o(fifo_empty_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic expect_status(input string nm, input int cnt, input logic ovf, input int drops);
        n_chk++;
        if (fifo_count_o !== cnt[$clog2(DEPTH):0] || fifo_empty_o !== (cnt == 0) ||
            overflow_o !== ovf || drop_cnt_o !== drops[DROP_W-1:0]) begin
            n_fail++;
            $display("FAIL %s: count=%0d empty=%b ovf=%b drops=%0d, want count=%0d empty=%b ovf=%b drops=%0d",
                     nm, fifo_count_o, fifo_empty_o, overflow_o, drop_cnt_o, cnt, (cnt == 0), ovf, drops);
        end
    endtask

    // Model: entry stored iff the FIFO is below capacity (no pops while ACK is held low).
    task automatic push_burst(input int n, output int drops);
        drops = 0;
        for (int i = 0; i < n; i++) begin
            neuron_idx_i   = M'($urandom);
            neuron_spike_i = 1'b1;
            if (q.size() < DEPTH) q.push_back(neuron_idx_i);
            else drops++;
            tick();
        end
        neuron_spike_i = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_status_i = 1'b1;
        tick();
        clr_status_i = 1'b0;
    endtask

    task automatic recv(input string nm);
        int t;
        logic [M-1:0] exp;
        exp = q.pop_front();
        t = 0;
        while (aerout_req_o !== 1'b1 && t < 40) begin tick(); t++; end
        n_chk++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL %s req_timeout: req=%b, want 1", nm, aerout_req_o);
        end else if (aerout_addr_o !== exp) begin
            n_fail++;
            $display("FAIL %s addr: got %h want %h", nm, aerout_addr_o, exp);
        end
        aerout_ack_i = 1'b1;
        t = 0;
        while (aerout_req_o !== 1'b0 && t < 40) begin tick(); t++; end
        n_chk++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL %s req_release_timeout: req=%b, want 0", nm, aerout_req_o);
        end
        aerout_ack_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        while (q.size() > 0) recv(nm);
        repeat (LAT + 3) tick();
        expect_status({nm, "_drained"}, 0, overflow_o, int'(drop_cnt_o));
    endtask

    task automatic test_reset();
        tick();
        n_chk++;
        if (aerout_req_o !== 1'b0 || aerout_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_aer: req=%b addr=%h, want 0/00", aerout_req_o, aerout_addr_o);
        end
        expect_status("reset_status", 0, 1'b0, 0);
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_single();
        neuron_idx_i = 8'h2A; neuron_spike_i = 1'b1;
        tick();
        neuron_spike_i = 1'b0;
        expect_status("single_edge1", 1, 1'b0, 0);
        tick();
        n_chk++;
        if (aerout_addr_o !== 8'h2A || aerout_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_edge2: addr=%h req=%b, want 2a/0", aerout_addr_o, aerout_req_o);
        end
        tick();
        n_chk++;
        if (aerout_req_o !== 1'b1 || aerout_addr_o !== 8'h2A) begin
            n_fail++;
            $display("FAIL single_edge3: req=%b addr=%h, want 1/2a", aerout_req_o, aerout_addr_o);
        end
        tick(); tick();
        aerout_ack_i = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick();
            n_chk++;
            if (aerout_req_o !== 1'b1) begin
                n_fail++;
                $display("FAIL single_ack_latency: req=%b at +%0d, want 1", aerout_req_o, i + 1);
            end
        end
        tick();
        n_chk++;
        if (aerout_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req_fall: req=%b, want 0", aerout_req_o);
        end
        expect_status("single_popped", 0, 1'b0, 0);
        aerout_ack_i = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    task automatic test_fill();
        int d;
        push_burst(DEPTH, d);
        expect_status("fill_16", DEPTH, 1'b0, 0);
        drain("fill_drain");
    endtask

    task automatic test_overflow();
        int d;
        push_burst(DEPTH + 4, d);
        expect_status("overflow_20", DEPTH, 1'b1, d);
        clr_pulse();
        expect_status("overflow_clr", DEPTH, 1'b0, 0);
    endtask

    // FIFO is left full by test_overflow; push lands on the same edge as the pop.
    task automatic test_full_pop();
        n_chk++;
        if (aerout_req_o !== 1'b1 || aerout_addr_o !== q[0]) begin
            n_fail++;
            $display("FAIL fullpop_head: req=%b addr=%h, want 1/%h", aerout_req_o, aerout_addr_o, q[0]);
        end
        aerout_ack_i = 1'b1;
        repeat (LAT) tick();
        neuron_idx_i = M'($urandom); neuron_spike_i = 1'b1;
        void'(q.pop_front());
        q.push_back(neuron_idx_i);
        tick();
        neuron_spike_i = 1'b0;
        aerout_ack_i = 1'b0;
        expect_status("fullpop_count", DEPTH, 1'b0, 0);
        drain("fullpop_drain");
    endtask

    task automatic test_random();
        int n, d;
        for (int it = 0; it < 4; it++) begin
            clr_pulse();
            n = $urandom_range(1, 24);
            push_burst(n, d);
            expect_status($sformatf("random_%0d_n%0d", it, n), (n < DEPTH) ? n : DEPTH, (n > DEPTH), d);
            drain($sformatf("random_%0d_drain", it));
        end
    endtask

    task automatic test_saturate();
        int d;
        clr_pulse();
        push_burst(DEPTH + 300, d);
        expect_status("saturate", DEPTH, 1'b1, (1 << DROP_W) - 1);
        neuron_spike_i = 1'b1; clr_status_i = 1'b1;
        tick();
        neuron_spike_i = 1'b0; clr_status_i = 1'b0;
        expect_status("clr_vs_drop", DEPTH, 1'b1, 1);
        clr_pulse();
        expect_status("clr_after", DEPTH, 1'b0, 0);
        drain("saturate_drain");
    endtask

    task automatic test_reset_mid();
        int d, t;
        push_burst(DEPTH + 2, d);
        for (int i = 0; i < DEPTH - 5; i++) recv("resetmid_pre");
        t = 0;
        while (aerout_req_o !== 1'b1 && t < 40) begin tick(); t++; end
        expect_status("resetmid_pre", 5, 1'b1, 2);
        #2 RST_N = 1'b0;
        #1;
        n_chk++;
        if (aerout_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL resetmid_req: req=%b, want 0", aerout_req_o);
        end
        expect_status("resetmid_async", 0, 1'b0, 0);
        q.delete();
        tick();
        RST_N = 1'b1;
        repeat (3) tick();
        n_chk++;
        if (aerout_req_o !== 1'b0 || fifo_empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL resetmid_after: req=%b empty=%b, want 0/1", aerout_req_o, fifo_empty_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_full_pop();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
